// File: rtl/ps2_frame_receiver_if.sv
// PS/2 receiver output bundle.
// Byte strobe, error strobe and busy flag.
interface ps2_frame_receiver_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_error;
  logic       rx_busy;

  modport master (
    output rx_byte,
    output rx_valid,
    output rx_error,
    output rx_busy
  );

  modport slave (
    input rx_byte,
    input rx_valid,
    input rx_error,
    input rx_busy
  );
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver.
// Filters the device clock, checks parity/stop, times out stalls.
module ps2_frame_receiver #(
  parameter logic [15:0] over_time    = 16'd1000,
  parameter int          filter_depth = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic peripheral_clock,
  input  logic device_clock,
  input  logic device_data,
  ps2_frame_receiver_if.master frame
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [3:0] FLT_LAST = 4'(filter_depth - 1);

  logic clk_s1, clk_s2;
  logic dat_s1, dat_s2;
  logic pclk_s1, pclk_s2, pclk_d;
  logic filt, filt_d;
  logic [3:0] fcnt;
  logic [1:0] state;
  logic [2:0] bitcnt;
  logic [7:0] shreg;
  logic par;
  logic [15:0] tcnt;
  logic [16:0] tnext;
  logic fall;
  logic tick;

  assign fall  = filt_d & ~filt;
  assign tick  = pclk_s2 & ~pclk_d;
  assign tnext = {1'b0, tcnt} + 17'd1;
  assign frame.rx_busy = (state != IDLE);

  // Two-flop synchronizers plus tick edge history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      pclk_s1 <= 1'b1;
      pclk_s2 <= 1'b1;
      pclk_d  <= 1'b1;
    end else begin
      clk_s1  <= device_clock;
      clk_s2  <= clk_s1;
      dat_s1  <= device_data;
      dat_s2  <= dat_s1;
      pclk_s1 <= peripheral_clock;
      pclk_s2 <= pclk_s1;
      pclk_d  <= pclk_s2;
    end
  end

  // Glitch filter: accept a new level after it persists
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt   <= 1'b1;
      filt_d <= 1'b1;
      fcnt   <= 4'd0;
    end else begin
      filt_d <= filt;
      if (clk_s2 == filt) begin
        fcnt <= 4'd0;
      end else if (fcnt == FLT_LAST) begin
        filt <= clk_s2;
        fcnt <= 4'd0;
      end else begin
        fcnt <= fcnt + 4'd1;
      end
    end
  end

  // Frame FSM, inactivity timeout and output strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bitcnt         <= 3'd0;
      shreg          <= 8'h00;
      par            <= 1'b0;
      tcnt           <= 16'd0;
      frame.rx_byte  <= 8'h00;
      frame.rx_valid <= 1'b0;
      frame.rx_error <= 1'b0;
    end else begin
      frame.rx_valid <= 1'b0;
      frame.rx_error <= 1'b0;
      if (fall) begin
        tcnt <= 16'd0;
        unique case (state)
          IDLE: begin
            if (!dat_s2) begin
              state  <= DATA;
              bitcnt <= 3'd0;
            end
          end
          DATA: begin
            shreg  <= {dat_s2, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s2;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s2 && (^{shreg, par})) begin
              frame.rx_valid <= 1'b1;
              frame.rx_byte  <= shreg;
            end else begin
              frame.rx_error <= 1'b1;
            end
          end
        endcase
      end else if (state == IDLE) begin
        tcnt <= 16'd0;
      end else if (tick) begin
        if (tnext == {1'b0, over_time}) begin
          frame.rx_error <= 1'b1;
          state          <= IDLE;
          tcnt           <= 16'd0;
        end else if (tcnt != 16'hFFFF) begin
          tcnt <= tnext[15:0];
        end
      end
    end
  end

endmodule
